dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Two-client arbiter and sequencer for the 4096 x 64 dual-port RAM. It sits between two independent requesters (client A, client B) and the RAM's single write port and single read port, which are granted independently with round-robin fairness. It returns registered read responses and forwards write data on a same-cycle, same-address read/write collision.

## Interface
- ADDR_W, 12, address width (RAM depth 2^ADDR_W)
- DATA_W, 64, data width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req_valid / b_req_valid  in  1  request present
- a_req_ready / b_req_ready  out  1  request accepted this cycle (combinational grant)
- a_req_we / b_req_we  in  1  1 = write, 0 = read
- a_req_addr / b_req_addr  in  ADDR_W  word address
- a_req_wdata / b_req_wdata  in  DATA_W  write data
- a_rsp_valid / b_rsp_valid  out  1  read data valid, one-cycle pulse
- a_rsp_rdata / b_rsp_rdata  out  DATA_W  read data
- ram_wr  out  1  RAM write enable
- ram_wr_add  out  ADDR_W  RAM write address
- ram_in  out  DATA_W  RAM write data
- ram_rd  out  1  RAM read enable
- ram_rd_add  out  ADDR_W  RAM read address
- ram_out  in  DATA_W  RAM read data (registered in RAM, 1-cycle latency, 0 when not read)

## Operation
- Request accepted when req_valid && req_ready. Client holds valid, we, addr and wdata stable until accepted.
- Write port and read port are arbitrated separately. A write from one client and a read from the other are both granted in the same cycle.
- Contention on one port: the client holding that port's priority bit (wr_prio, rd_prio) wins.
- On any grant of a port to client X, that port's priority moves to the other client. Under continuous contention grants strictly alternate.
- Granted write: ram_wr=1, ram_wr_add/ram_in from the winner. Otherwise ram_wr=0 and ram_wr_add/ram_in=0.
- Granted read: ram_rd=1, ram_rd_add from the winner. Otherwise ram_rd=0 and ram_rd_add=0.
- Read pipeline:
  - Stage 1 registers owner (A/B), valid and collision info at accept.
  - Stage 2 registers the response data: ram_out, or the forwarded write data.
- Collision: a read and a write granted in the same cycle to the same address. The response returns that cycle's write data, not the RAM's old data.
- Responses are in order per client and have no backpressure. Clients must accept rsp_valid whenever it is asserted.
- rsp_rdata holds its last value when rsp_valid=0.
- Addresses wrap naturally at ADDR_W bits. 0xFFF is a legal address.

## Timing
- Reset values:
  - wr_prio=A, rd_prio=A.
  - Pipeline valids=0.
  - a/b_rsp_valid=0, a/b_rsp_rdata=0.
  - Grants forced to 0 while rst_n=0, so req_ready=0 and ram_wr=ram_rd=0.
- Reset is asynchronous assert. Deassert is sampled on the clk edge. Reset mid-operation discards all in-flight reads; no rsp_valid is produced for them after release.
- Command path is combinational: req_valid/we/addr -> req_ready and ram_* in the same cycle. req_ready never depends on rsp signals.
- Read latency: accept at edge N.
  - RAM captures the read at edge N.
  - Stage 2 registers the data at edge N+1.
  - rsp_valid is high for cycle N+1 to N+2, i.e. 2 cycles after accept.
- Write latency: data is in the RAM after the accept edge. A read of the same address accepted 1+ cycles later returns the new data with no forwarding needed.
- Throughput: one write plus one read per cycle total. One request per client per cycle.
- A single client issuing back-to-back reads gets back-to-back rsp_valid pulses.

## Test plan
- Reset: hold rst_n=0 with both clients valid. Required: ready=0, ram_wr=ram_rd=0, rsp_valid=0, rsp_rdata=0. After release, the first contended grant goes to A.
- Write then read:
  - A writes addr 0x123, data 0xDEADBEEF00000001.
  - Next cycle A reads 0x123.
  - Required: a_rsp_valid exactly 2 cycles after the read accept, a_rsp_rdata=0xDEADBEEF00000001, b_rsp_valid stays 0.
- Write contention: A and B each post 4 writes to 0x000..0x003 continuously. Required: grants alternate A,B,A,B..., 8 writes complete in 8 cycles, and later reads return the values written.
- Collision forwarding:
  - 0x010 preloaded with 0x1111111111111111.
  - In the same cycle, A writes 0x010 with 0x2222222222222222 and B reads 0x010.
  - Required: both ready=1, b_rsp_rdata=0x2222222222222222.
- Read contention at wrap:
  - 0xFFF=0xAA..AA, 0x000=0x55..55.
  - A and B both read 0xFFF, then 0x000.
  - Required: grants alternate, 4 responses, each in order per client with correct data.
- Reset mid-read: accept an A read, drop rst_n on the next cycle for 2 cycles. Required: no a_rsp_valid after release, rsp_rdata=0.

Source files
------------

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: two-client round-robin arbiter for the write port and the
// read port of a dual-port RAM. Read responses come back through a two-stage
// pipeline. A read and a write granted together to the same address return
// the new write data instead of the RAM's old contents.
module dpram_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  // client A
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,
  // client B
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,
  // RAM ports
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_wr_add,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_rd_add,
  input  logic [DATA_W-1:0] ram_out
);

  // Priority bits: 0 = client A wins contention, 1 = client B wins.
  logic r_wr_prio;
  logic r_rd_prio;

  logic w_a_wr, w_b_wr, w_a_rd, w_b_rd;
  logic w_gnt_wr_a, w_gnt_wr_b, w_gnt_rd_a, w_gnt_rd_b;
  logic w_wr_gnt, w_rd_gnt, w_col;

  // Read pipeline stage 1 (control resets, forwarded data does not).
  logic              r_vld_p1;
  logic              r_own_p1;
  logic              r_col_p1;
  logic [DATA_W-1:0] r_fwd_p1;
  logic [DATA_W-1:0] w_rdata_p1;

  // Read pipeline stage 2 (the response registers).
  logic              r_a_vld_p2;
  logic              r_b_vld_p2;
  logic [DATA_W-1:0] r_a_rdata_p2;
  logic [DATA_W-1:0] r_b_rdata_p2;

  assign w_a_wr = a_req_valid &  a_req_we;
  assign w_b_wr = b_req_valid &  b_req_we;
  assign w_a_rd = a_req_valid & ~a_req_we;
  assign w_b_rd = b_req_valid & ~b_req_we;

  // Per-port grant: the priority holder wins a tie; all grants held off in reset.
  always_comb begin
    w_gnt_wr_a = 1'b0;
    w_gnt_wr_b = 1'b0;
    w_gnt_rd_a = 1'b0;
    w_gnt_rd_b = 1'b0;
    if (rst_n) begin
      if (w_a_wr && w_b_wr) begin
        w_gnt_wr_a = ~r_wr_prio;
        w_gnt_wr_b =  r_wr_prio;
      end else begin
        w_gnt_wr_a = w_a_wr;
        w_gnt_wr_b = w_b_wr;
      end
      if (w_a_rd && w_b_rd) begin
        w_gnt_rd_a = ~r_rd_prio;
        w_gnt_rd_b =  r_rd_prio;
      end else begin
        w_gnt_rd_a = w_a_rd;
        w_gnt_rd_b = w_b_rd;
      end
    end
  end

  assign w_wr_gnt = w_gnt_wr_a | w_gnt_wr_b;
  assign w_rd_gnt = w_gnt_rd_a | w_gnt_rd_b;

  // A client issues at most one request per cycle, so ready is the OR of its port grants.
  assign a_req_ready = w_gnt_wr_a | w_gnt_rd_a;
  assign b_req_ready = w_gnt_wr_b | w_gnt_rd_b;

  // RAM command mux; ungranted ports drive zero.
  always_comb begin
    ram_wr     = w_wr_gnt;
    ram_wr_add = '0;
    ram_in     = '0;
    ram_rd     = w_rd_gnt;
    ram_rd_add = '0;
    if (w_gnt_wr_a) begin
      ram_wr_add = a_req_addr;
      ram_in     = a_req_wdata;
    end else if (w_gnt_wr_b) begin
      ram_wr_add = b_req_addr;
      ram_in     = b_req_wdata;
    end
    if (w_gnt_rd_a) begin
      ram_rd_add = a_req_addr;
    end else if (w_gnt_rd_b) begin
      ram_rd_add = b_req_addr;
    end
  end

  assign w_col = w_wr_gnt & w_rd_gnt & (ram_wr_add == ram_rd_add);

  // Hand each port's priority to the other client after every grant of that port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_prio <= 1'b0;
      r_rd_prio <= 1'b0;
    end else begin
      if (w_gnt_wr_a) begin
        r_wr_prio <= 1'b1;
      end else if (w_gnt_wr_b) begin
        r_wr_prio <= 1'b0;
      end
      if (w_gnt_rd_a) begin
        r_rd_prio <= 1'b1;
      end else if (w_gnt_rd_b) begin
        r_rd_prio <= 1'b0;
      end
    end
  end

  // ---- stage 1: note who owns the accepted read and whether it collided ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_own_p1 <= 1'b0;
      r_col_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_gnt;
      r_own_p1 <= w_gnt_rd_b;
      r_col_p1 <= w_col;
    end
  end

  // Capture the write data that a colliding read must return instead of the RAM's stale word.
  always_ff @(posedge clk) begin
    if (w_col) begin
      r_fwd_p1 <= ram_in;
    end
  end

  assign w_rdata_p1 = r_col_p1 ? r_fwd_p1 : ram_out;

  // ---- stage 2: register the response; rdata holds between pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_vld_p2   <= 1'b0;
      r_b_vld_p2   <= 1'b0;
      r_a_rdata_p2 <= '0;
      r_b_rdata_p2 <= '0;
    end else begin
      r_a_vld_p2 <= r_vld_p1 & ~r_own_p1;
      r_b_vld_p2 <= r_vld_p1 &  r_own_p1;
      if (r_vld_p1 && !r_own_p1) begin
        r_a_rdata_p2 <= w_rdata_p1;
      end
      if (r_vld_p1 && r_own_p1) begin
        r_b_rdata_p2 <= w_rdata_p1;
      end
    end
  end

  assign a_rsp_valid = r_a_vld_p2;
  assign a_rsp_rdata = r_a_rdata_p2;
  assign b_rsp_valid = r_b_vld_p2;
  assign b_rsp_rdata = r_b_rdata_p2;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: directed scenarios plus a randomized run
// compared against a memory-array reference model of the arbitration rules.
module tb_dpram_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_rdata;
  logic          ram_wr, ram_rd;
  logic [AW-1:0] ram_wr_add, ram_rd_add;
  logic [DW-1:0] ram_in, ram_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference memory and priority state: 1 means client B holds priority.
  logic [DW-1:0] ref_mem [0:4095];
  bit            wr_pri_b;
  bit            rd_pri_b;

  // Observed responses, collected for the directed scenarios.
  logic [DW-1:0] mon_a_d[$];
  logic [DW-1:0] mon_b_d[$];
  int            mon_a_c[$];
  int            mon_b_c[$];

  // RAM model: registered read of old contents, 0 when not reading.
  logic [DW-1:0] bram [0:4095];
  logic          tb_clr;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 4096; i++) bram[i] <= '0;
    end else if (ram_wr) begin
      bram[ram_wr_add] <= ram_in;
    end
    ram_out <= (!tb_clr && ram_rd) ? bram[ram_rd_add] : '0;
  end

  always @(negedge clk) begin
    if (a_rsp_valid) begin
      mon_a_d.push_back(a_rsp_rdata);
      mon_a_c.push_back(cyc);
    end
    if (b_rsp_valid) begin
      mon_b_d.push_back(b_rsp_rdata);
      mon_b_c.push_back(cyc);
    end
  end

  dpram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_wr(ram_wr), .ram_wr_add(ram_wr_add), .ram_in(ram_in),
    .ram_rd(ram_rd), .ram_rd_add(ram_rd_add), .ram_out(ram_out)
  );

  task automatic drive(input logic av, input logic awe, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input logic bv, input logic bwe,
                       input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_req_valid = av; a_req_we = awe; a_req_addr = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
  endtask

  task automatic idle(input int n);
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_mon();
    mon_a_d.delete(); mon_a_c.delete(); mon_b_d.delete(); mon_b_c.delete();
  endtask

  task automatic test_reset();
    drive(1, 1, 12'h100, 64'h0000_0000_0000_0100, 1, 1, 12'h101, 64'h0000_0000_0000_0101);
    repeat (2) @(negedge clk);
    checks++;
    if ({a_req_ready, b_req_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready: got %b want 00", {a_req_ready, b_req_ready});
    end
    checks++;
    if ({ram_wr, ram_rd} !== 2'b00) begin
      failures++; $display("FAIL reset_ram_en: got %b want 00", {ram_wr, ram_rd});
    end
    checks++;
    if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_rsp_valid: got %b want 00", {a_rsp_valid, b_rsp_valid});
    end
    checks++;
    if (a_rsp_rdata !== '0 || b_rsp_rdata !== '0) begin
      failures++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_rsp_rdata, b_rsp_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; tb_clr = 1'b0;
    wr_pri_b = 0; rd_pri_b = 0;
    @(negedge clk);
    checks++;
    if ({a_req_ready, b_req_ready, ram_wr, ram_wr_add} !== {1'b1, 1'b0, 1'b1, 12'h100}) begin
      failures++; $display("FAIL reset_first_grant: got rdy=%b%b wr=%b add=%h want rdy=10 wr=1 add=100",
                           a_req_ready, b_req_ready, ram_wr, ram_wr_add);
    end
    ref_mem[12'h100] = 64'h100; wr_pri_b = 1;
    @(posedge clk); #1;
    drive(0, 0, '0, '0, 1, 1, 12'h101, 64'h0000_0000_0000_0101);
    @(negedge clk);
    checks++;
    if ({a_req_ready, b_req_ready, ram_wr_add} !== {1'b0, 1'b1, 12'h101}) begin
      failures++; $display("FAIL reset_second_grant: got rdy=%b%b add=%h want rdy=01 add=101",
                           a_req_ready, b_req_ready, ram_wr_add);
    end
    ref_mem[12'h101] = 64'h101; wr_pri_b = 0;
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_write_read();
    int k;
    clear_mon();
    drive(1, 1, 12'h123, 64'hDEADBEEF00000001, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({a_req_ready, ram_wr, ram_wr_add, ram_in} !== {1'b1, 1'b1, 12'h123, 64'hDEADBEEF00000001}) begin
      failures++; $display("FAIL wr_cmd: got rdy=%b wr=%b add=%h in=%h want 1 1 123 deadbeef00000001",
                           a_req_ready, ram_wr, ram_wr_add, ram_in);
    end
    ref_mem[12'h123] = 64'hDEADBEEF00000001; wr_pri_b = 1;
    @(posedge clk); #1;
    drive(1, 0, 12'h123, '0, 0, 0, '0, '0);
    @(negedge clk);
    k = cyc;
    checks++;
    if ({a_req_ready, ram_rd, ram_rd_add} !== {1'b1, 1'b1, 12'h123}) begin
      failures++; $display("FAIL rd_cmd: got rdy=%b rd=%b add=%h want 1 1 123", a_req_ready, ram_rd, ram_rd_add);
    end
    rd_pri_b = 1;
    @(posedge clk); #1;
    idle(4);
    checks++;
    if (mon_a_d.size() != 1 || mon_a_c[0] != k + 2 || mon_a_d[0] !== 64'hDEADBEEF00000001) begin
      failures++; $display("FAIL wr_rd_rsp: got n=%0d cyc=%0d data=%h want n=1 cyc=%0d data=deadbeef00000001",
                           mon_a_d.size(), (mon_a_c.size() > 0) ? mon_a_c[0] - k : -1,
                           (mon_a_d.size() > 0) ? mon_a_d[0] : '0, 2);
    end
    checks++;
    if (mon_b_d.size() != 0) begin
      failures++; $display("FAIL wr_rd_b_quiet: got %0d b responses want 0", mon_b_d.size());
    end
  endtask

  task automatic test_write_contention();
    logic [DW-1:0] da [0:3];
    logic [DW-1:0] db [0:3];
    int ia = 0, ib = 0, k0 = 0;
    bit wa, wb;
    for (int i = 0; i < 4; i++) begin
      da[i] = 64'hA000_0000_0000_0000 | 64'(i);
      db[i] = 64'hB000_0000_0000_0000 | 64'(i);
    end
    for (int c = 0; c < 8; c++) begin
      drive(ia < 4, 1, AW'(ia & 3), da[ia & 3], ib < 4, 1, AW'(ib & 3), db[ib & 3]);
      @(negedge clk);
      if (ia < 4 && ib < 4) begin wa = !wr_pri_b; wb = wr_pri_b; end
      else begin wa = (ia < 4); wb = (ib < 4); end
      checks++;
      if ({a_req_ready, b_req_ready} !== {wa, wb}) begin
        failures++; $display("FAIL wr_cont_grant c%0d: got %b%b want %b%b", c, a_req_ready, b_req_ready, wa, wb);
      end
      checks++;
      if (ram_wr_add !== (wa ? AW'(ia & 3) : AW'(ib & 3)) || ram_in !== (wa ? da[ia & 3] : db[ib & 3])) begin
        failures++; $display("FAIL wr_cont_cmd c%0d: got add=%h in=%h", c, ram_wr_add, ram_in);
      end
      if (wa) begin ref_mem[ia & 3] = da[ia & 3]; wr_pri_b = 1; end
      if (wb) begin ref_mem[ib & 3] = db[ib & 3]; wr_pri_b = 0; end
      if (a_req_ready) ia++;
      if (b_req_ready) ib++;
      @(posedge clk); #1;
    end
    checks++;
    if (ia != 4 || ib != 4) begin
      failures++; $display("FAIL wr_cont_done: got a=%0d b=%0d want 4 4 in 8 cycles", ia, ib);
    end
    idle(1);
    clear_mon();
    for (int r = 0; r < 4; r++) begin
      drive(1, 0, AW'(r), '0, 0, 0, '0, '0);
      @(negedge clk);
      if (r == 0) k0 = cyc;
      @(posedge clk); #1;
    end
    rd_pri_b = 1;
    idle(4);
    checks++;
    if (mon_a_d.size() != 4) begin
      failures++; $display("FAIL wr_cont_readback_n: got %0d want 4", mon_a_d.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (mon_a_c[j] != k0 + 2 + j || mon_a_d[j] !== ref_mem[j]) begin
          failures++; $display("FAIL wr_cont_readback%0d: got %h at +%0d want %h at +%0d",
                               j, mon_a_d[j], mon_a_c[j] - k0, ref_mem[j], 2 + j);
        end
      end
    end
  endtask

  task automatic test_collision();
    int k;
    drive(1, 1, 12'h010, 64'h1111111111111111, 0, 0, '0, '0);
    @(posedge clk); #1;
    ref_mem[12'h010] = 64'h1111111111111111; wr_pri_b = 1;
    clear_mon();
    drive(1, 1, 12'h010, 64'h2222222222222222, 1, 0, 12'h010, '0);
    @(negedge clk);
    k = cyc;
    checks++;
    if ({a_req_ready, b_req_ready, ram_wr, ram_rd} !== 4'b1111) begin
      failures++; $display("FAIL coll_grant: got rdy=%b%b wr=%b rd=%b want 1111",
                           a_req_ready, b_req_ready, ram_wr, ram_rd);
    end
    ref_mem[12'h010] = 64'h2222222222222222; wr_pri_b = 1; rd_pri_b = 0;
    @(posedge clk); #1;
    idle(4);
    checks++;
    if (mon_b_d.size() != 1 || mon_b_c[0] != k + 2 || mon_b_d[0] !== 64'h2222222222222222) begin
      failures++; $display("FAIL coll_fwd: got n=%0d data=%h want n=1 data=2222222222222222",
                           mon_b_d.size(), (mon_b_d.size() > 0) ? mon_b_d[0] : '0);
    end
    checks++;
    if (mon_a_d.size() != 0) begin
      failures++; $display("FAIL coll_a_quiet: got %0d a responses want 0", mon_a_d.size());
    end
  endtask

  task automatic test_read_wrap();
    logic [AW-1:0] seq [0:1];
    int ia = 0, ib = 0;
    bit ra, rb;
    seq[0] = 12'hFFF; seq[1] = 12'h000;
    drive(1, 1, 12'hFFF, {16{4'hA}}, 0, 0, '0, '0);
    @(posedge clk); #1;
    drive(1, 1, 12'h000, {16{4'h5}}, 0, 0, '0, '0);
    @(posedge clk); #1;
    ref_mem[12'hFFF] = {16{4'hA}}; ref_mem[12'h000] = {16{4'h5}}; wr_pri_b = 1;
    clear_mon();
    for (int c = 0; c < 4; c++) begin
      drive(ia < 2, 0, seq[ia & 1], '0, ib < 2, 0, seq[ib & 1], '0);
      @(negedge clk);
      if (ia < 2 && ib < 2) begin ra = !rd_pri_b; rb = rd_pri_b; end
      else begin ra = (ia < 2); rb = (ib < 2); end
      checks++;
      if ({a_req_ready, b_req_ready, ram_rd_add} !== {ra, rb, ra ? seq[ia & 1] : seq[ib & 1]}) begin
        failures++; $display("FAIL rd_wrap_grant c%0d: got rdy=%b%b add=%h want rdy=%b%b add=%h", c,
                             a_req_ready, b_req_ready, ram_rd_add, ra, rb, ra ? seq[ia & 1] : seq[ib & 1]);
      end
      if (ra) rd_pri_b = 1;
      if (rb) rd_pri_b = 0;
      if (a_req_ready) ia++;
      if (b_req_ready) ib++;
      @(posedge clk); #1;
    end
    idle(4);
    checks++;
    if (mon_a_d.size() != 2 || mon_b_d.size() != 2) begin
      failures++; $display("FAIL rd_wrap_count: got a=%0d b=%0d want 2 2", mon_a_d.size(), mon_b_d.size());
    end else begin
      checks++;
      if (mon_a_d[0] !== {16{4'hA}} || mon_a_d[1] !== {16{4'h5}}) begin
        failures++; $display("FAIL rd_wrap_a_data: got %h %h want aa.. 55..", mon_a_d[0], mon_a_d[1]);
      end
      checks++;
      if (mon_b_d[0] !== {16{4'hA}} || mon_b_d[1] !== {16{4'h5}}) begin
        failures++; $display("FAIL rd_wrap_b_data: got %h %h want aa.. 55..", mon_b_d[0], mon_b_d[1]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    clear_mon();
    drive(1, 0, 12'h123, '0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_mid_accept: got %b want 1", a_req_ready);
    end
    @(posedge clk); #1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wr_pri_b = 0; rd_pri_b = 0;
    idle(4);
    checks++;
    if (mon_a_d.size() != 0 || mon_b_d.size() != 0) begin
      failures++; $display("FAIL rst_mid_no_rsp: got a=%0d b=%0d responses want 0 0", mon_a_d.size(), mon_b_d.size());
    end
    checks++;
    if (a_rsp_rdata !== '0 || b_rsp_rdata !== '0) begin
      failures++; $display("FAIL rst_mid_rdata: got %h/%h want 0/0", a_rsp_rdata, b_rsp_rdata);
    end
  endtask

  task automatic test_random();
    bit            a_p = 0, b_p = 0, a_we = 0, b_we = 0;
    logic [AW-1:0] a_ad = '0, b_ad = '0, wad, rad;
    logic [DW-1:0] a_wd = '0, b_wd = '0, wdat, rdat;
    logic [DW-1:0] ea_d[$], eb_d[$];
    int            ea_c[$], eb_c[$];
    logic [DW-1:0] last_a = '0, last_b = '0;
    bit gwa, gwb, gra, grb;
    for (int c = 0; c < 406; c++) begin
      if (c < 400 && !a_p && $urandom_range(0, 9) < 7) begin
        a_p = 1; a_we = $urandom_range(0, 1);
        a_ad = ($urandom_range(0, 3) == 0) ? 12'hFFF : AW'($urandom_range(0, 7));
        a_wd = {$urandom, $urandom};
      end
      if (c < 400 && !b_p && $urandom_range(0, 9) < 7) begin
        b_p = 1; b_we = $urandom_range(0, 1);
        b_ad = ($urandom_range(0, 3) == 0) ? 12'hFFF : AW'($urandom_range(0, 7));
        b_wd = {$urandom, $urandom};
      end
      drive(a_p, a_we, a_ad, a_wd, b_p, b_we, b_ad, b_wd);
      @(negedge clk);
      // responses due this cycle
      checks++;
      if (a_rsp_valid) begin
        if (ea_d.size() == 0 || ea_c[0] != cyc || ea_d[0] !== a_rsp_rdata) begin
          failures++; $display("FAIL rand_a_rsp cyc%0d: got %h want %h due %0d", cyc, a_rsp_rdata,
                               (ea_d.size() > 0) ? ea_d[0] : '0, (ea_c.size() > 0) ? ea_c[0] : -1);
        end
        if (ea_d.size() > 0) begin void'(ea_d.pop_front()); void'(ea_c.pop_front()); end
        last_a = a_rsp_rdata;
      end else if (a_rsp_rdata !== last_a || (ea_c.size() > 0 && ea_c[0] <= cyc)) begin
        failures++; $display("FAIL rand_a_idle cyc%0d: got valid=0 rdata=%h want rdata=%h pending=%0d",
                             cyc, a_rsp_rdata, last_a, ea_c.size());
        if (ea_c.size() > 0 && ea_c[0] <= cyc) begin void'(ea_d.pop_front()); void'(ea_c.pop_front()); end
      end
      checks++;
      if (b_rsp_valid) begin
        if (eb_d.size() == 0 || eb_c[0] != cyc || eb_d[0] !== b_rsp_rdata) begin
          failures++; $display("FAIL rand_b_rsp cyc%0d: got %h want %h due %0d", cyc, b_rsp_rdata,
                               (eb_d.size() > 0) ? eb_d[0] : '0, (eb_c.size() > 0) ? eb_c[0] : -1);
        end
        if (eb_d.size() > 0) begin void'(eb_d.pop_front()); void'(eb_c.pop_front()); end
        last_b = b_rsp_rdata;
      end else if (b_rsp_rdata !== last_b || (eb_c.size() > 0 && eb_c[0] <= cyc)) begin
        failures++; $display("FAIL rand_b_idle cyc%0d: got valid=0 rdata=%h want rdata=%h pending=%0d",
                             cyc, b_rsp_rdata, last_b, eb_c.size());
        if (eb_c.size() > 0 && eb_c[0] <= cyc) begin void'(eb_d.pop_front()); void'(eb_c.pop_front()); end
      end
      // who should win each port this cycle
      gwa = a_p && a_we && !(b_p && b_we && wr_pri_b);
      gwb = b_p && b_we && !(a_p && a_we && !wr_pri_b);
      gra = a_p && !a_we && !(b_p && !b_we && rd_pri_b);
      grb = b_p && !b_we && !(a_p && !a_we && !rd_pri_b);
      wad  = gwa ? a_ad : (gwb ? b_ad : '0);
      wdat = gwa ? a_wd : (gwb ? b_wd : '0);
      rad  = gra ? a_ad : (grb ? b_ad : '0);
      checks++;
      if ({a_req_ready, b_req_ready} !== {gwa | gra, gwb | grb}) begin
        failures++; $display("FAIL rand_ready cyc%0d: got %b%b want %b%b", cyc,
                             a_req_ready, b_req_ready, gwa | gra, gwb | grb);
      end
      checks++;
      if ({ram_wr, ram_wr_add, ram_in} !== {gwa | gwb, wad, wdat}) begin
        failures++; $display("FAIL rand_wr_cmd cyc%0d: got %b %h %h want %b %h %h", cyc,
                             ram_wr, ram_wr_add, ram_in, gwa | gwb, wad, wdat);
      end
      checks++;
      if ({ram_rd, ram_rd_add} !== {gra | grb, rad}) begin
        failures++; $display("FAIL rand_rd_cmd cyc%0d: got %b %h want %b %h", cyc,
                             ram_rd, ram_rd_add, gra | grb, rad);
      end
      // reads see this cycle's write to the same word, otherwise the stored word
      if (gra || grb) begin
        rdat = ((gwa || gwb) && wad == rad) ? wdat : ref_mem[rad];
        if (gra) begin ea_d.push_back(rdat); ea_c.push_back(cyc + 2); end
        else     begin eb_d.push_back(rdat); eb_c.push_back(cyc + 2); end
      end
      if (gwa || gwb) ref_mem[wad] = wdat;
      if (gwa) wr_pri_b = 1;
      if (gwb) wr_pri_b = 0;
      if (gra) rd_pri_b = 1;
      if (grb) rd_pri_b = 0;
      if (a_req_ready) a_p = 0;
      if (b_req_ready) b_p = 0;
      @(posedge clk); #1;
    end
    checks++;
    if (ea_d.size() != 0 || eb_d.size() != 0 || a_p || b_p) begin
      failures++; $display("FAIL rand_drain: got pending rsp a=%0d b=%0d req a=%b b=%b want all 0",
                           ea_d.size(), eb_d.size(), a_p, b_p);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    tb_clr = 1'b1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    wr_pri_b = 0;
    rd_pri_b = 0;
    test_reset();
    test_write_read();
    test_write_contention();
    test_collision();
    test_read_wrap();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
